// File: rtl/core_pkg.sv
// Shared definitions for the instruction fetch stage: default address width,
// default reset PC, fetch FSM states and the queued {pc, inst} entry type.
package core_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] pc;
    logic [31:0]               inst;
  } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs. A clear empties it
// in one cycle and overrides any push or pop issued alongside it.
module fq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Storage is not reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential PC generation, memory requests, and a
// {pc, inst} queue toward decode. Optional counters under FETCH_PERF_EN.
module fetch_queue
  import core_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              misalign_err,
  output logic              halted
`ifdef FETCH_PERF_EN
 ,output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t        state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   tag_pc;
  logic                inflight;
  logic                drop;
  logic                rst_q;
  logic [CW-1:0]       count;
  logic [ADDR_W+31:0]  head;
  logic                accept;
  logic                push;
  logic                pop;

  // Credit rule: never request unless the FIFO has room for the response.
  assign imem_req  = !rst && (state == RUN) && ((int'(count) + int'(inflight)) < DEPTH)
                     && !redirect_valid;
  assign imem_addr = {fetch_pc[ADDR_W-1:2], 2'b00};
  assign accept    = imem_req && imem_gnt;

  assign push = imem_rvalid && inflight && !drop && !rst_q && !redirect_valid;
  assign if_valid = (count != '0);
  assign pop      = if_valid && if_ready && !redirect_valid;
  assign if_pc    = if_valid ? head[ADDR_W+31:32] : '0;
  assign if_inst  = if_valid ? head[31:0] : '0;
  assign halted   = (state == HALT) && !if_valid && !inflight;

  // rst_q shields the queue from a stale response arriving just after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      fetch_pc     <= RESET_PC;
      tag_pc       <= '0;
      inflight     <= 1'b0;
      drop         <= 1'b0;
      rst_q        <= 1'b1;
      misalign_err <= 1'b0;
    end else begin
      rst_q        <= 1'b0;
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      inflight     <= accept || (inflight && !imem_rvalid);
      if (imem_rvalid) begin
        drop <= 1'b0;
      end
      if (accept) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        tag_pc   <= imem_addr;
      end
      // A response still outstanding past the redirect belongs to the old path.
      if (redirect_valid) begin
        state    <= RUN;
        fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        drop     <= inflight && !imem_rvalid;
      end else if ((state == RUN) && halt) begin
        state <= HALT;
      end
    end
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + 32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({tag_pc, imem_rdata}),
    .head  (head),
    .count (count)
  );

`ifdef FETCH_PERF_EN
  // Saturating counters: queued instructions and decode-starved cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (push && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (if_ready && !if_valid && (state == RUN) && (perf_bubbles != 32'hFFFF_FFFF)) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model of the fetch stage.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, halt, imem_gnt, imem_rvalid, if_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid, misalign_err, halted;
  logic [31:0] imem_addr, if_pc, if_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .misalign_err(misalign_err), .halted(halted)
`ifdef FETCH_PERF_EN
   ,.perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;

  // Reference model state
  ent_t        m_q[$];
  logic [31:0] m_pc, m_pend_pc, m_fetched, m_bubbles;
  bit          m_run, m_infl, m_mis, m_rstq, m_pend_v;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_acc  = 0;
  int mis_cnt  = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, advance the model,
  // then drive the memory response for the following cycle.
  task automatic tick();
    bit   exp_req, acc, resp;
    ent_t e;
    logic [31:0] issue_pc;
    #1;
    exp_req = !rst && m_run && ((m_q.size() + int'(m_infl)) < DEPTH) && !redirect_valid;
    check("imem_req", 64'(imem_req), 64'(exp_req));
    check("imem_addr", 64'(imem_addr), 64'(m_pc));
    check("if_valid", 64'(if_valid), 64'(m_q.size() != 0));
    check("if_pc", 64'(if_pc), (m_q.size() != 0) ? 64'(m_q[0].pc) : 64'h0);
    check("if_inst", 64'(if_inst), (m_q.size() != 0) ? 64'(m_q[0].inst) : 64'h0);
    check("misalign_err", 64'(misalign_err), 64'(m_mis));
    check("halted", 64'(halted), 64'(!m_run && (m_q.size() == 0) && !m_infl));
`ifdef FETCH_PERF_EN
    check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    check("perf_bubbles", 64'(perf_bubbles), 64'(m_bubbles));
`endif
    if (imem_req && imem_gnt) dut_acc++;
    if (misalign_err) mis_cnt++;

    if (rst) begin
      m_q.delete();
      m_pc = 32'h0; m_run = 1; m_infl = 0; m_mis = 0; m_rstq = 1;
      m_pend_v = 1; m_pend_pc = $urandom;
      m_fetched = 0; m_bubbles = 0;
    end else begin
      acc      = exp_req && imem_gnt;
      resp     = imem_rvalid && m_infl && !m_rstq;
      issue_pc = m_pc;
      if (if_ready && (m_q.size() == 0) && m_run && (m_bubbles != 32'hFFFF_FFFF)) m_bubbles++;
      if (redirect_valid) begin
        m_q.delete();
        m_pc  = {redirect_pc[31:2], 2'b00};
        m_run = 1;
        m_mis = (redirect_pc[1:0] != 2'b00);
      end else begin
        m_mis = 0;
        if (if_ready && (m_q.size() != 0)) void'(m_q.pop_front());
        if (resp) begin
          e = '{pc: m_pend_pc, inst: imem_rdata};
          m_q.push_back(e);
          if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
        end
        if (acc) m_pc = m_pc + 32'd4;
        if (m_run && halt) m_run = 0;
      end
      m_infl = acc; m_pend_v = acc; m_pend_pc = issue_pc; m_rstq = 0;
    end

    @(posedge clk);
    #1;
    imem_rvalid    = m_pend_v;
    imem_rdata     = mem_word(m_pend_pc);
    redirect_valid = 0;
    halt           = 0;
  endtask

  task automatic applyStimulus(int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic resetCycle();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic redirectTo(logic [31:0] pc);
    redirect_valid = 1; redirect_pc = pc; tick();
  endtask

  initial begin
    rst = 1; redirect_valid = 0; redirect_pc = 0; halt = 0;
    imem_gnt = 1; imem_rvalid = 0; imem_rdata = 0; if_ready = 1;
    m_q.delete();
    m_pc = 0; m_run = 1; m_infl = 0; m_mis = 0; m_rstq = 1;
    m_pend_v = 0; m_pend_pc = 0; m_fetched = 0; m_bubbles = 0;
    repeat (2) @(posedge clk);
    #1;

    // Sequential fetch with a stale response right after reset release
    resetCycle();
    applyStimulus(8);

    // Decode stalled: exactly DEPTH requests, then drain in order
    resetCycle();
    if_ready = 0; dut_acc = 0;
    applyStimulus(10);
    check("stall_req_count", 64'(dut_acc), 64'(DEPTH));
    if_ready = 1;
    applyStimulus(6);

    // Grant withheld mid-stream
    imem_gnt = 0; applyStimulus(3);
    imem_gnt = 1; applyStimulus(5);

    // Redirect with FIFO at 3 and one response in flight
    resetCycle();
    if_ready = 0;
    applyStimulus(4);
    redirectTo(32'h40);
    if_ready = 1;
    applyStimulus(6);

    // Misaligned redirect target
    mis_cnt = 0;
    redirectTo(32'h42);
    applyStimulus(5);
    check("misalign_pulses", 64'(mis_cnt), 64'd1);

    // Halt, drain, then resume at 0x100
    resetCycle();
    if_ready = 0;
    applyStimulus(3);
    halt = 1;
    applyStimulus(3);
    if_ready = 1;
    applyStimulus(6);
    #1;
    check("halted_drained", 64'(halted), 64'd1);
    redirectTo(32'h100);
    #1;
    check("resume_req", 64'(imem_req), 64'd1);
    check("resume_addr", 64'(imem_addr), 64'h100);
    applyStimulus(6);

    // Address wrap past the top of the address space
    redirectTo(32'hFFFF_FFF8);
    applyStimulus(8);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      imem_gnt = ($urandom_range(0, 3) != 0);
      if_ready = ($urandom_range(0, 4) > 1);
      r = $urandom_range(0, 99);
      rst = (r == 6);
      if (r < 3) begin
        redirect_valid = 1;
        redirect_pc    = (r == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(0, 3))) : $urandom;
      end else if (r < 6) begin
        halt = 1;
      end
      tick();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
